// File: rtl/lfsr_rng_ranged_if.sv
// rtl/lfsr_rng_ranged_if.sv - request/seed/result bundle for the ranged LFSR random source
//
// Ports (grouped signals):
//   seed_load  1      load seed into the LFSR on this edge
//   seed       WIDTH  seed value (0 is replaced by 1)
//   req        1      request a ranged number, sampled only while idle
//   modulus    WIDTH  modulus captured with an accepted req, 0 = raw snapshot
//   busy       1      reduction in progress
//   valid      1      one-cycle pulse, value updated
//   value      WIDTH  last result, held until the next valid
//   state      WIDTH  live LFSR register
// Modports: master = requester side (game FSM), slave = generator side.
interface lfsr_rng_ranged_if #(
  parameter int WIDTH = 10
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             req;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] state;

  modport master (
    output seed_load, seed, req, modulus,
    input  busy, valid, value, state
  );

  modport slave (
    input  seed_load, seed, req, modulus,
    output busy, valid, value, state
  );
endinterface

// File: rtl/lfsr_rng_ranged.sv
// rtl/lfsr_rng_ranged.sv - free-running Galois LFSR with on-demand modulo-reduced output
//
// Ports:
//   clk    in   single rising-edge clock
//   reset  in   synchronous, active-high
//   bus    slave modport of lfsr_rng_ranged_if (seed_load, seed, req, modulus in;
//          busy, valid, value, state out)
// Parameters:
//   WIDTH       LFSR/seed/modulus/result width, 4..16
//   TAPS        Galois feedback mask in right-shift form, must be maximal-length
//   RESET_SEED  LFSR value after reset, nonzero
module lfsr_rng_ranged #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(10'h240),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_rng_ranged_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    REDUCE
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  // Partial remainder is < mod before the shift, so the shifted value needs one
  // extra bit; after the conditional subtract it fits back into WIDTH bits.
  logic [WIDTH:0]   rem_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      lfsr_q  <= RESET_SEED;
      snap_q  <= '0;
      mod_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      snap_q  <= snap_d;
      mod_q   <= mod_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    snap_d    = snap_q;
    mod_d     = mod_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    rem_shift = {rem_q, snap_q[cnt_q]};

    // The LFSR runs independently of the reducer; a seed load only replaces
    // the shift, it never touches a reduction already in flight.
    if (bus.seed_load) begin
      lfsr_d = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    end else begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    case (fsm_q)
      IDLE: begin
        if (bus.req) begin
          // Snapshot the pre-update register, even when a seed load lands on the same edge.
          snap_d = lfsr_q;
          mod_d  = bus.modulus;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH - 1);
          fsm_d  = REDUCE;
        end
      end
      REDUCE: begin
        // One restoring-division step per edge, MSB first; always WIDTH steps
        // so latency does not depend on the operands.
        if (rem_shift >= {1'b0, mod_q}) begin
          rem_d = WIDTH'(rem_shift - {1'b0, mod_q});
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
        end
        if (cnt_q == '0) begin
          value_d = (mod_q == '0) ? snap_q : rem_d;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.busy  = (fsm_q == REDUCE);
  assign bus.valid = valid_q;
  assign bus.value = value_q;
  assign bus.state = lfsr_q;

endmodule
